// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants and types for the round-robin mux arbiter.
// Holds the state encoding, select encodings and the one-hot helper.
package mux_arb_pkg;

    localparam int unsigned NUM_SRC          = 4;
    localparam int unsigned SEL_W            = 2;
    localparam int unsigned HOLD_W           = 8;
    localparam int unsigned MAX_HOLD_DEFAULT = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] SEL_A = 2'b00;
    localparam logic [SEL_W-1:0] SEL_B = 2'b01;
    localparam logic [SEL_W-1:0] SEL_C = 2'b10;
    localparam logic [SEL_W-1:0] SEL_D = 2'b11;

    function automatic logic [NUM_SRC-1:0] onehot4(input logic [SEL_W-1:0] idx);
        return NUM_SRC'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick4.sv
// Rotating-priority picker: first set request after index last, wrapping mod 4.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic [SEL_W-1:0]   idx,
    output logic               found
);

    // Walk from the farthest offset down so the nearest hit after last wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            if (req[SEL_W'(last + SEL_W'(k))]) begin
                idx   = SEL_W'(last + SEL_W'(k));
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning a shared 4:1 mux: grants one source at a time,
// drives the registered selects and captures the selected word onto A.
module rr_mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] req,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    input  logic [WIDTH-1:0]   d,
    output logic [NUM_SRC-1:0] gnt,
    output logic               s1,
    output logic               s2,
    output logic [WIDTH-1:0]   A,
    output logic               A_valid
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t              state, state_nxt;
    logic [NUM_SRC-1:0]  gnt_nxt;
    logic [SEL_W-1:0]    sel, sel_nxt;
    logic [SEL_W-1:0]    last, last_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic [SEL_W-1:0]    pick_idx_c;
    logic                pick_found_c;
    logic                others_c;
    logic [WIDTH-1:0]    mux_c;

    rr_pick4 u_pick (
        .req   (req),
        .last  (last),
        .idx   (pick_idx_c),
        .found (pick_found_c)
    );

    // In GRANT the owner is always the most recent grantee.
    assign others_c = |(req & ~onehot4(last));

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        sel_nxt   = sel;
        last_nxt  = last;
        hold_nxt  = hold_cnt;
        unique case (state)
            ST_IDLE: begin
                gnt_nxt = '0;
                if (pick_found_c) begin
                    state_nxt = ST_GRANT;
                    gnt_nxt   = onehot4(pick_idx_c);
                    sel_nxt   = pick_idx_c;
                    last_nxt  = pick_idx_c;
                    hold_nxt  = '0;
                end
            end
            ST_GRANT: begin
                if (req[last]) begin
                    if (hold_cnt < HOLD_LAST) begin
                        hold_nxt = HOLD_W'(hold_cnt + HOLD_W'(1));
                    end else begin
                        hold_nxt = '0;
                        if (others_c) begin
                            gnt_nxt  = onehot4(pick_idx_c);
                            sel_nxt  = pick_idx_c;
                            last_nxt = pick_idx_c;
                        end
                    end
                end else if (pick_found_c) begin
                    gnt_nxt  = onehot4(pick_idx_c);
                    sel_nxt  = pick_idx_c;
                    last_nxt = pick_idx_c;
                    hold_nxt = '0;
                end else begin
                    state_nxt = ST_IDLE;
                    gnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            sel      <= SEL_A;
            last     <= SEL_D;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            sel      <= sel_nxt;
            last     <= last_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // Inline 4:1 select, same encoding as the external Mux41.
    always_comb begin
        unique case (sel)
            SEL_A:   mux_c = a;
            SEL_B:   mux_c = b;
            SEL_C:   mux_c = c;
            SEL_D:   mux_c = d;
            default: mux_c = a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A       <= '0;
            A_valid <= 1'b0;
        end else begin
            if (state == ST_GRANT) begin
                A <= mux_c;
            end
            A_valid <= (state == ST_GRANT);
        end
    end

    assign s1 = sel[1];
    assign s2 = sel[0];

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: a behavioural arbiter model predicts
// grants and pushes expected output words; a monitor pops and compares.
module tb_rr_mux_arbiter;

    localparam int unsigned W  = 8;
    localparam int unsigned MH = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req = 4'b0000;
    logic [W-1:0] a, b, c, d;
    logic [3:0]   gnt;
    logic         s1, s2;
    logic [W-1:0] A;
    logic         A_valid;

    int errors = 0;
    int checks = 0;

    rr_mux_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .a(a), .b(b), .c(c), .d(d),
        .gnt(gnt), .s1(s1), .s2(s2), .A(A), .A_valid(A_valid)
    );

    always #5 clk = ~clk;

    // Sources toggle at 20/30/50/70 ns periods, offset so no toggle hits a clock edge.
    initial begin a = 8'h5a; #2; forever begin #10 a = ~a; end end
    initial begin b = 8'h3c; #2; forever begin #15 b = ~b; end end
    initial begin c = 8'h0f; #2; forever begin #25 c = ~c; end end
    initial begin d = 8'h96; #2; forever begin #35 d = ~d; end end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: who owns the mux, for how long, and the last grantee.
    bit           m_busy;
    int           m_owner;
    int           m_last;
    int           m_cnt;
    logic [1:0]   m_sel;
    bit           exp_valid;
    logic [W-1:0] exp_q[$];

    function automatic int pick(input logic [3:0] r, input int l);
        for (int k = 1; k <= 4; k++) begin
            if (r[(l + k) % 4]) return (l + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] src(input int i);
        case (i)
            0: return a;
            1: return b;
            2: return c;
            default: return d;
        endcase
    endfunction

    task automatic take(input int i);
        m_busy  = 1'b1;
        m_owner = i;
        m_last  = i;
        m_sel   = 2'(i);
        m_cnt   = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_owner = 0; m_last = 3; m_cnt = 0; m_sel = 2'b00;
            exp_valid = 1'b0;
            exp_q.delete();
        end else begin
            exp_valid = m_busy;
            if (m_busy) exp_q.push_back(src(m_owner));
            if (!m_busy) begin
                if (req != 4'b0000) take(pick(req, m_last));
            end else if (req[m_owner]) begin
                if (m_cnt < MH - 1) m_cnt++;
                else if ((req & ~(4'b0001 << m_owner)) != 4'b0000) take(pick(req, m_last));
                else m_cnt = 0;
            end else if (req != 4'b0000) begin
                take(pick(req, m_last));
            end else begin
                m_busy = 1'b0;
            end
        end
    end

    // Monitor: compares registered outputs mid-cycle against the model.
    always @(negedge clk) begin
        logic [W-1:0] w;
        if (rst_n) begin
            check("gnt", 32'(gnt), m_busy ? 32'(4'b0001 << m_owner) : 32'd0);
            check("sel", 32'({s1, s2}), 32'(m_sel));
            check("A_valid", 32'(A_valid), 32'(exp_valid));
            if (A_valid) begin
                if (exp_q.size() == 0) begin
                    check("A_unexpected", 32'(1), 32'(0));
                end else begin
                    w = exp_q.pop_front();
                    check("A", 32'(A), 32'(w));
                end
            end
        end
    end

    task automatic run(input logic [3:0] r, input int n);
        repeat (n) begin
            @(negedge clk);
            req = r;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run(4'b0000, 3);
        // First grant from reset, then an asynchronous reset mid-grant.
        run(4'b0100, 5);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_s1", 32'(s1), 32'd0);
        check("rst_s2", 32'(s2), 32'd0);
        check("rst_A", 32'(A), 32'd0);
        check("rst_A_valid", 32'(A_valid), 32'd0);
        #4 rst_n = 1'b1;
        run(4'b0100, 4);
        run(4'b0000, 3);
        // All four requesting from reset: strict a,b,c,d rotation.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #5 rst_n = 1'b1;
        run(4'b1111, 40);
        run(4'b0000, 3);
        // Owner a drops while d waits.
        run(4'b0001, 3);
        run(4'b1001, 2);
        run(4'b1000, 4);
        run(4'b0000, 3);
        // Sole requester keeps the grant across hold-limit wraps.
        run(4'b0010, 20);
        run(4'b0000, 3);
        // Rotating request pattern with toggling data.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            req = (4'b0001 << ((i / 3) % 4)) | (4'b0001 << ((i / 7) % 4));
        end
        // Randomized requests.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
        end
        run(4'b0000, 4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
